// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage in front of the ALU: valid/ready in, decoded bundle out one cycle later.
// Optional DECODE_SKID_EN adds a one-entry skid buffer so o_ready is a flop with no path from i_ready.
module alu_decode_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [3:0]  o_alu_op,
  output logic [1:0]  o_src_a_sel,
  output logic [1:0]  o_src_b_sel,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_reg_we,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic        o_is_branch,
  output logic        o_is_jump,
  output logic [2:0]  o_funct3,
  output logic        o_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SLL  = 4'b0001, ALU_SLT  = 4'b0010, ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100, ALU_SRL  = 4'b0101, ALU_OR   = 4'b0110, ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000, ALU_BGEU = 4'b1001, ALU_BLTU = 4'b1010, ALU_BGE  = 4'b1011,
    ALU_BLT  = 4'b1100, ALU_SRA  = 4'b1101, ALU_BNE  = 4'b1111
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011, OPC_OP_IMM = 7'b0010011, OPC_AUIPC = 7'b0010111,
    OPC_STORE  = 7'b0100011, OPC_OP     = 7'b0110011, OPC_LUI   = 7'b0110111,
    OPC_BRANCH = 7'b1100011, OPC_JALR   = 7'b1100111, OPC_JAL   = 7'b1101111
  } opcode_e;

  typedef enum logic [1:0] {SRC_A_RS1 = 2'b00, SRC_A_PC = 2'b01, SRC_A_ZERO = 2'b10} src_a_e;
  typedef enum logic [1:0] {SRC_B_RS2 = 2'b00, SRC_B_IMM = 2'b01, SRC_B_FOUR = 2'b10} src_b_e;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [1:0]  src_a;
    logic [1:0]  src_b;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        is_branch;
    logic        is_jump;
    logic [2:0]  funct3;
    logic        illegal;
  } decode_t;

  function automatic alu_op_e f_alu_map(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_illegal;
  decode_t     w_dec;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u  = {i_instr[31:12], 12'h000};
  assign w_imm_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  always_comb begin
    w_illegal       = 1'b0;
    w_dec           = '0;
    w_dec.alu_op    = ALU_ADD;
    w_dec.src_a     = SRC_A_RS1;
    w_dec.src_b     = SRC_B_RS2;
    w_dec.rs1       = i_instr[19:15];
    w_dec.rs2       = i_instr[24:20];
    w_dec.rd        = i_instr[11:7];
    w_dec.funct3    = w_f3;
    case (w_opcode)
      OPC_OP_IMM: begin
        w_dec.alu_op = f_alu_map(w_f3, (w_f3 == 3'b101) && i_instr[30]);
        w_dec.src_b  = SRC_B_IMM;
        w_dec.imm    = w_imm_i;
        w_dec.reg_we = 1'b1;
        if (w_f3 == 3'b001 && w_f7 != 7'b0000000)
          w_illegal = 1'b1;
        if (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000)
          w_illegal = 1'b1;
      end
      OPC_OP: begin
        w_dec.alu_op = f_alu_map(w_f3, w_f7 == 7'b0100000);
        w_dec.reg_we = 1'b1;
        if (w_f7 == 7'b0100000) begin
          if (w_f3 != 3'b000 && w_f3 != 3'b101)
            w_illegal = 1'b1;
        end else if (w_f7 != 7'b0000000) begin
          w_illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        w_dec.imm       = w_imm_b;
        w_dec.is_branch = 1'b1;
        case (w_f3)
          3'b000:  w_dec.alu_op = ALU_SUB;
          3'b001:  w_dec.alu_op = ALU_BNE;
          3'b100:  w_dec.alu_op = ALU_BLT;
          3'b101:  w_dec.alu_op = ALU_BGE;
          3'b110:  w_dec.alu_op = ALU_BLTU;
          3'b111:  w_dec.alu_op = ALU_BGEU;
          default: w_illegal    = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_dec.src_b  = SRC_B_IMM;
        w_dec.imm    = w_imm_i;
        w_dec.reg_we = 1'b1;
        w_dec.mem_rd = 1'b1;
      end
      OPC_STORE: begin
        w_dec.src_b  = SRC_B_IMM;
        w_dec.imm    = w_imm_s;
        w_dec.mem_wr = 1'b1;
      end
      OPC_LUI: begin
        w_dec.src_a  = SRC_A_ZERO;
        w_dec.src_b  = SRC_B_IMM;
        w_dec.imm    = w_imm_u;
        w_dec.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.src_a  = SRC_A_PC;
        w_dec.src_b  = SRC_B_IMM;
        w_dec.imm    = w_imm_u;
        w_dec.reg_we = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        w_dec.src_a   = SRC_A_PC;
        w_dec.src_b   = SRC_B_FOUR;
        w_dec.imm     = (w_opcode == OPC_JAL) ? w_imm_j : w_imm_i;
        w_dec.reg_we  = 1'b1;
        w_dec.is_jump = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    // Illegal words keep their register fields but carry no operation or side effect.
    if (w_illegal) begin
      w_dec.alu_op    = ALU_ADD;
      w_dec.src_a     = SRC_A_RS1;
      w_dec.src_b     = SRC_B_RS2;
      w_dec.imm       = '0;
      w_dec.reg_we    = 1'b0;
      w_dec.mem_rd    = 1'b0;
      w_dec.mem_wr    = 1'b0;
      w_dec.is_branch = 1'b0;
      w_dec.is_jump   = 1'b0;
      w_dec.illegal   = 1'b1;
    end
  end

  decode_t r_out;
  logic    r_valid;
  logic    w_out_free;
  logic    w_accept;

  assign w_out_free = !r_valid || i_ready;

`ifdef DECODE_SKID_EN
  decode_t r_skid;
  logic    r_skid_valid;
  logic    r_ready;

  assign o_ready  = r_ready;
  assign w_accept = i_valid && r_ready;

  // Skid only fills while the output is stalled, and always drains before new input is taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out        <= '0;
      r_valid      <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (i_flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_valid      <= 1'b1;
        r_skid_valid <= 1'b0;
        r_ready      <= 1'b1;
      end else if (w_accept) begin
        r_out   <= w_dec;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
      r_ready      <= 1'b0;
    end
  end
`else
  assign o_ready  = w_out_free;
  assign w_accept = i_valid && w_out_free;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_out   <= w_dec;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
`endif

  assign o_valid     = r_valid;
  assign o_alu_op    = r_out.alu_op;
  assign o_src_a_sel = r_out.src_a;
  assign o_src_b_sel = r_out.src_b;
  assign o_imm       = r_out.imm;
  assign o_rs1       = r_out.rs1;
  assign o_rs2       = r_out.rs2;
  assign o_rd        = r_out.rd;
  assign o_reg_we    = r_out.reg_we;
  assign o_mem_rd    = r_out.mem_rd;
  assign o_mem_wr    = r_out.mem_wr;
  assign o_is_branch = r_out.is_branch;
  assign o_is_jump   = r_out.is_jump;
  assign o_funct3    = r_out.funct3;
  assign o_illegal   = r_out.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: driver pushes hand-computed bundles, monitor pops on output transfers.
module tb_alu_decode_stage;

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        mrd;
    logic        mwr;
    logic        br;
    logic        jmp;
    logic [2:0]  f3;
    logic        ill;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_instr = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [3:0]  o_alu_op;
  logic [1:0]  o_src_a_sel, o_src_b_sel;
  logic [31:0] o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic        o_reg_we, o_mem_rd, o_mem_wr, o_is_branch, o_is_jump;
  logic [2:0]  o_funct3;
  logic        o_illegal;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  exp_t        q[$];

  alu_decode_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_alu_op(o_alu_op), .o_src_a_sel(o_src_a_sel), .o_src_b_sel(o_src_b_sel),
    .o_imm(o_imm), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
    .o_reg_we(o_reg_we), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
    .o_is_branch(o_is_branch), .o_is_jump(o_is_jump), .o_funct3(o_funct3),
    .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  function automatic exp_t actual();
    return '{o_alu_op, o_src_a_sel, o_src_b_sel, o_imm, o_rs1, o_rs2, o_rd,
             o_reg_we, o_mem_rd, o_mem_wr, o_is_branch, o_is_jump, o_funct3, o_illegal};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: occupancy model, hold stability, ready behaviour, and in-order bundle comparison.
  logic prev_hold = 1'b0;
  exp_t prev_bundle;
  always begin
    @(negedge i_clk);
    #1;
    if (!i_rst_n) begin
      prev_hold = 1'b0;
    end else begin
      check("valid_vs_occupancy", {63'd0, o_valid}, {63'd0, q.size() > 0});
`ifdef DECODE_SKID_EN
      check("ready_skid", {63'd0, o_ready}, {63'd0, q.size() < 2});
`else
      check("ready_comb", {63'd0, o_ready}, {63'd0, (q.size() == 0) || i_ready});
`endif
      if (prev_hold) begin
        check("hold_valid", {63'd0, o_valid}, 64'd1);
        check("hold_stable", actual(), prev_bundle);
      end
      prev_hold   = o_valid && !i_ready && !i_flush;
      prev_bundle = actual();
      if (i_flush) begin
        q.delete();
      end else if (o_valid && i_ready) begin
        if (q.size() == 0) check("unexpected_output", actual(), 64'd0 - 64'd1);
        else check("bundle", actual(), q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] ins, input exp_t e);
    int unsigned n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_instr = ins;
      #2;
      if (o_ready) begin
        done = 1;
        q.push_back(e);
      end
      n++;
      if (!done && n > 50) begin
        check("send_timeout", 64'd0, 64'd1);
        done = 1;
      end
    end
  endtask

  task automatic idle();
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    i_ready = 1'b1;
    idle();
    while (q.size() != 0 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check("drain_empty", {32'd0, q.size()}, 64'd0);
  endtask

  logic [31:0] vi[16];
  exp_t        ve[16];

  initial begin
    vi[0]  = 32'hFFF10093; ve[0]  = '{4'h0, 2'd0, 2'd1, 32'hFFFFFFFF, 5'd2, 5'd31, 5'd1, 1, 0, 0, 0, 0, 3'd0, 0};
    vi[1]  = 32'h40B50533; ve[1]  = '{4'h8, 2'd0, 2'd0, 32'h0, 5'd10, 5'd11, 5'd10, 1, 0, 0, 0, 0, 3'd0, 0};
    vi[2]  = 32'h40B55533; ve[2]  = '{4'hD, 2'd0, 2'd0, 32'h0, 5'd10, 5'd11, 5'd10, 1, 0, 0, 0, 0, 3'd5, 0};
    vi[3]  = 32'h00B51463; ve[3]  = '{4'hF, 2'd0, 2'd0, 32'h8, 5'd10, 5'd11, 5'd8, 0, 0, 0, 1, 0, 3'd1, 0};
    vi[4]  = 32'h02B50533; ve[4]  = '{4'h0, 2'd0, 2'd0, 32'h0, 5'd10, 5'd11, 5'd10, 0, 0, 0, 0, 0, 3'd0, 1};
    vi[5]  = 32'h00C32283; ve[5]  = '{4'h0, 2'd0, 2'd1, 32'hC, 5'd6, 5'd12, 5'd5, 1, 1, 0, 0, 0, 3'd2, 0};
    vi[6]  = 32'hFE742E23; ve[6]  = '{4'h0, 2'd0, 2'd1, 32'hFFFFFFFC, 5'd8, 5'd7, 5'd28, 0, 0, 1, 0, 0, 3'd2, 0};
    vi[7]  = 32'h123451B7; ve[7]  = '{4'h0, 2'd2, 2'd1, 32'h12345000, 5'd8, 5'd3, 5'd3, 1, 0, 0, 0, 0, 3'd5, 0};
    vi[8]  = 32'h00001217; ve[8]  = '{4'h0, 2'd1, 2'd1, 32'h1000, 5'd0, 5'd0, 5'd4, 1, 0, 0, 0, 0, 3'd1, 0};
    vi[9]  = 32'h010000EF; ve[9]  = '{4'h0, 2'd1, 2'd2, 32'h10, 5'd0, 5'd16, 5'd1, 1, 0, 0, 0, 1, 3'd0, 0};
    vi[10] = 32'h00008067; ve[10] = '{4'h0, 2'd1, 2'd2, 32'h0, 5'd1, 5'd0, 5'd0, 1, 0, 0, 0, 1, 3'd0, 0};
    vi[11] = 32'h40335293; ve[11] = '{4'hD, 2'd0, 2'd1, 32'h403, 5'd6, 5'd3, 5'd5, 1, 0, 0, 0, 0, 3'd5, 0};
    vi[12] = 32'h40331293; ve[12] = '{4'h0, 2'd0, 2'd0, 32'h0, 5'd6, 5'd3, 5'd5, 0, 0, 0, 0, 0, 3'd1, 1};
    vi[13] = 32'h0000007F; ve[13] = '{4'h0, 2'd0, 2'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 3'd0, 1};
    vi[14] = 32'hFE208EE3; ve[14] = '{4'h8, 2'd0, 2'd0, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd29, 0, 0, 0, 1, 0, 3'd0, 0};
    vi[15] = 32'h00002063; ve[15] = '{4'h0, 2'd0, 2'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 3'd2, 1};

    // Reset values
    #1 i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    check("reset_valid", {63'd0, o_valid}, 64'd0);
    check("reset_ready", {63'd0, o_ready}, 64'd1);
    check("reset_bundle", actual(), 64'd0);
    i_rst_n = 1'b1;

    // Back-to-back decode of every vector with the consumer always ready
    i_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(vi[i], ve[i]);
    drain();

    // Consumer stalls three cycles while upstream keeps offering
    fork
      begin
        send(vi[5], ve[5]); send(vi[6], ve[6]); send(vi[7], ve[7]); send(vi[8], ve[8]);
      end
      begin
        @(negedge i_clk); i_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        i_ready = 1'b1;
      end
    join
    drain();

    // Flush while a bundle is held and a new one is accepted on the same edge
    i_ready = 1'b0;
    send(vi[1], ve[1]);
    @(negedge i_clk);
    i_valid = 1'b1; i_instr = vi[2]; i_flush = 1'b1; i_ready = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0; i_valid = 1'b0;
    #3;
    check("flush_valid", {63'd0, o_valid}, 64'd0);
    check("flush_ready", {63'd0, o_ready}, 64'd1);
    send(vi[3], ve[3]);
    drain();

    // Reset asserted while a bundle is held
    i_ready = 1'b0;
    send(vi[0], ve[0]);
    idle();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    q.delete();
    #3;
    check("midreset_valid", {63'd0, o_valid}, 64'd0);
    check("midreset_ready", {63'd0, o_ready}, 64'd1);
    check("midreset_bundle", actual(), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    send(vi[9], ve[9]);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
